// File: rtl/masked_rand_source_pkg.sv
// masked_rand_source_pkg
//   Shared definitions for the masked randomness source and its consumers.
//   Holds the pair-index helpers used by the HPC1 multiplier, the LFSR
//   geometry and taps, the reset-seed base, the FSM state type, and the
//   32-step LFSR advance function.
package masked_rand_source_pkg;

  localparam int unsigned LFSR_WIDTH = 32;

  // x^32 + x^22 + x^2 + x + 1 as a mask over state bits 31, 21, 1, 0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [31:0] RESET_SEED_BASE = 32'hACE1_0000;

  // Stand-in for an all-zero seed word, which would lock the LFSR.
  localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEED,
    ST_WARMUP,
    ST_RUN
  } state_t;

  // Number of share pairs (i<j) for n shares.
  function automatic int unsigned num_quad(input int unsigned n);
    return (n * (n - 1)) / 2;
  endfunction

  // Row-major position of pair (i,j), i<j, among n shares.
  function automatic int unsigned qindex(input int unsigned n,
                                         input int unsigned i,
                                         input int unsigned j);
    return (i * n) - ((i * (i + 1)) / 2) + (j - i - 1);
  endfunction

  // State after 32 Fibonacci shifts; the feedback bit enters at bit 0.
  function automatic logic [31:0] lfsr_advance32(input logic [31:0] state);
    logic [31:0] s;
    s = state;
    for (int unsigned i = 0; i < LFSR_WIDTH; i++) begin
      s = {s[30:0], ^(s & LFSR_TAPS)};
    end
    return s;
  endfunction

endpackage

// File: rtl/masked_rand_source_lfsr32_unrolled.sv
// lfsr32_unrolled
//   One 32-bit Fibonacci LFSR register. Load has priority over advance;
//   a zero load word is replaced with ZERO_SEED_SUB. Each advance applies
//   32 single-bit steps, so the whole word is renewed.
//   Optional macro RAND_SOURCE_HEALTH_EN adds the health_fail flag.
// Ports:
//   clk, reset      clock, synchronous active-high reset (loads RESET_VALUE)
//   load, load_value seed load
//   advance         step the register by 32 bits
//   value           low OUT_W bits of the state
//   check           (health) enable the repetition comparison this cycle
//   health_fail     (health) state is zero, or a checked advance repeats
module lfsr32_unrolled
  import masked_rand_source_pkg::*;
#(
  parameter logic [31:0] RESET_VALUE  = RESET_SEED_BASE,
  parameter int unsigned OUT_W        = 32,
  parameter bit          CHECK_REPEAT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [31:0]      load_value,
  input  logic             advance,
  output logic [OUT_W-1:0] value
`ifdef RAND_SOURCE_HEALTH_EN
  ,
  input  logic             check,
  output logic             health_fail
`endif
);

  logic [31:0] state;
  logic [31:0] state_next;

  assign state_next = lfsr_advance32(state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_VALUE;
    end else if (load) begin
      state <= (load_value == '0) ? ZERO_SEED_SUB : load_value;
    end else if (advance) begin
      state <= state_next;
    end
  end

  assign value = state[OUT_W-1:0];

`ifdef RAND_SOURCE_HEALTH_EN
  assign health_fail = (state == '0) ||
                       (CHECK_REPEAT && check && advance && (state_next == state));
`endif

endmodule

// File: rtl/masked_rand_source.sv
// masked_rand_source
//   Fresh-randomness generator for the masked HPC1 multipliers. A bank of
//   NUM_LFSR 32-bit LFSRs is seeded word by word, warmed up for
//   WARMUP_CYCLES advances, then advanced once per in_enable in RUN.
//   {out_p, out_r} is the low OUT_BITS of {lfsr[NUM_LFSR-1], ..., lfsr[0]}.
//   Optional macro RAND_SOURCE_HEALTH_EN enables the sticky health check.
// Ports:
//   in_clock, in_reset           clock, synchronous active-high reset
//   in_seed, in_seed_valid,
//   out_seed_ready               seed word handshake (SEED state only)
//   in_reseed                    drop back to SEED, word index 0
//   in_enable                    advance in RUN
//   out_r, out_p                 refresh and pair randomness
//   out_valid                    outputs are seeded and fresh
//   out_error                    sticky health failure (0 without the macro)
module masked_rand_source
  import masked_rand_source_pkg::*;
#(
  parameter int unsigned NUM_SHARES    = 2,
  parameter int unsigned BIT_WIDTH     = 1,
  parameter int unsigned WARMUP_CYCLES = 4
) (
  input  logic                                       in_clock,
  input  logic                                       in_reset,
  input  logic [31:0]                                in_seed,
  input  logic                                       in_seed_valid,
  output logic                                       out_seed_ready,
  input  logic                                       in_reseed,
  input  logic                                       in_enable,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]            out_r,
  output logic [num_quad(NUM_SHARES)*BIT_WIDTH-1:0]  out_p,
  output logic                                       out_valid,
  output logic                                       out_error
);

  localparam int unsigned NUM_QUAD = num_quad(NUM_SHARES);
  localparam int unsigned OUT_BITS = (NUM_SHARES + NUM_QUAD) * BIT_WIDTH;
  localparam int unsigned NUM_LFSR = (OUT_BITS + LFSR_WIDTH - 1) / LFSR_WIDTH;
  localparam int unsigned KW       = (NUM_LFSR > 1) ? $clog2(NUM_LFSR) : 1;
  localparam int unsigned WW       = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NUM_LFSR - 1);
  localparam logic [WW-1:0] LAST_W = WW'(WARMUP_CYCLES - 1);

  state_t        state, state_n;
  logic [KW-1:0] seed_idx, seed_idx_n;
  logic [WW-1:0] warm_cnt, warm_cnt_n;
  logic          accept;
  logic          advance;
  logic [OUT_BITS-1:0] flat;

  // Reseed outranks both a same-cycle accept and any advance, so the
  // current vector is left untouched when the consumer asks for a reseed.
  assign accept  = (state == ST_SEED) && in_seed_valid && !in_reseed;
  assign advance = !in_reseed &&
                   ((state == ST_WARMUP) || ((state == ST_RUN) && in_enable));

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state    <= ST_IDLE;
      seed_idx <= '0;
      warm_cnt <= '0;
    end else begin
      state    <= state_n;
      seed_idx <= seed_idx_n;
      warm_cnt <= warm_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    seed_idx_n = seed_idx;
    warm_cnt_n = warm_cnt;
    case (state)
      ST_IDLE: begin
        state_n    = ST_SEED;
        seed_idx_n = '0;
      end
      ST_SEED: begin
        if (accept) begin
          if (seed_idx == LAST_K) begin
            state_n    = ST_WARMUP;
            seed_idx_n = '0;
            warm_cnt_n = '0;
          end else begin
            seed_idx_n = seed_idx + KW'(1);
          end
        end
      end
      ST_WARMUP: begin
        if (warm_cnt == LAST_W) begin
          state_n = ST_RUN;
        end else begin
          warm_cnt_n = warm_cnt + WW'(1);
        end
      end
      ST_RUN: begin
      end
      default: state_n = ST_IDLE;
    endcase
    if (in_reseed && (state != ST_IDLE)) begin
      state_n    = ST_SEED;
      seed_idx_n = '0;
    end
  end

`ifdef RAND_SOURCE_HEALTH_EN
  logic [NUM_LFSR-1:0] health_fail;
`endif

  for (genvar k = 0; k < NUM_LFSR; k++) begin : g_lfsr
    localparam int unsigned LO = k * LFSR_WIDTH;
    localparam int unsigned OW = ((OUT_BITS - LO) > LFSR_WIDTH) ? LFSR_WIDTH : (OUT_BITS - LO);

    lfsr32_unrolled #(
      .RESET_VALUE (RESET_SEED_BASE + 32'(k)),
      .OUT_W       (OW),
      .CHECK_REPEAT(k == 0)
    ) u_lfsr (
      .clk        (in_clock),
      .reset      (in_reset),
      .load       (accept && (seed_idx == KW'(k))),
      .load_value (in_seed),
      .advance    (advance),
      .value      (flat[LO +: OW])
`ifdef RAND_SOURCE_HEALTH_EN
      ,
      .check      (state == ST_RUN),
      .health_fail(health_fail[k])
`endif
    );
  end

  assign {out_p, out_r} = flat;
  assign out_seed_ready = (state == ST_SEED);

`ifdef RAND_SOURCE_HEALTH_EN
  logic error;

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      error <= 1'b0;
    end else if (|health_fail) begin
      error <= 1'b1;
    end
  end

  assign out_error = error;
  assign out_valid = (state == ST_RUN) && !error;
`else
  assign out_error = 1'b0;
  assign out_valid = (state == ST_RUN);
`endif

endmodule

// File: tb/tb_masked_rand_source.sv
// tb_masked_rand_source
//   Directed bench for masked_rand_source configured with NUM_SHARES=3,
//   BIT_WIDTH=8 (OUT_BITS=48, two LFSRs), WARMUP_CYCLES=4.
module tb_masked_rand_source;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] seed;
  logic        seed_valid;
  logic        seed_ready;
  logic        reseed;
  logic        enable;
  logic [23:0] r;
  logic [23:0] p;
  logic        valid;
  logic        error;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m0, m1;
  logic [47:0] seq_a [4];
  logic [47:0] prev;
  logic [63:0] rst_cat;
  logic [5:0]  pat;

  masked_rand_source #(
    .NUM_SHARES   (3),
    .BIT_WIDTH    (8),
    .WARMUP_CYCLES(4)
  ) dut (
    .in_clock      (clk),
    .in_reset      (reset),
    .in_seed       (seed),
    .in_seed_valid (seed_valid),
    .out_seed_ready(seed_ready),
    .in_reseed     (reseed),
    .in_enable     (enable),
    .out_r         (r),
    .out_p         (p),
    .out_valid     (valid),
    .out_error     (error)
  );

  always #5 clk = ~clk;

  // Reference LFSR: explicit taps at bits 31, 21, 1, 0.
  function automatic logic [31:0] ref_adv(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < 32; i++) begin
      t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
    end
    return t;
  endfunction

  function automatic logic [31:0] sub0(input logic [31:0] w);
    return (w == 32'h0) ? 32'h0000_0001 : w;
  endfunction

  function automatic logic [47:0] model_out();
    logic [63:0] c;
    c = {m1, m0};
    return c[47:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_adv();
    m0 = ref_adv(m0);
    m1 = ref_adv(m1);
  endtask

  task automatic seed_two(input logic [31:0] a, input logic [31:0] b);
    seed_valid = 1'b1;
    seed       = a;
    tick();
    seed       = b;
    tick();
    seed_valid = 1'b0;
    seed       = '0;
    m0 = sub0(a);
    m1 = sub0(b);
  endtask

  // Four warm-up advances; valid must rise exactly after the fourth.
  task automatic warm();
    for (int i = 0; i < 4; i++) begin
      chk("valid_low_warmup", valid, 0);
      tick();
      model_adv();
    end
    chk("valid_rise", valid, 1);
    chk("warm_out", {p, r}, model_out());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    seed       = '0;
    seed_valid = 1'b0;
    reseed     = 1'b0;
    enable     = 1'b0;
    rst_cat    = {32'hACE1_0001, 32'hACE1_0000};
    tick();
    tick();

    // Reset state
    chk("rst_ready", seed_ready, 0);
    chk("rst_valid", valid, 0);
    chk("rst_error", error, 0);
    chk("rst_out", {p, r}, rst_cat[47:0]);

    // Idle -> seed, no seed words offered; enable must have no effect
    reset  = 1'b0;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("seed_ready_hold", seed_ready, 1);
      chk("seed_valid_low", valid, 0);
      chk("seed_out_hold", {p, r}, rst_cat[47:0]);
      tick();
    end
    enable = 1'b0;

    // Zero first seed word, substituted with 1
    seed_two(32'h0000_0000, 32'h9ABC_DEF0);
    chk("zero_sub_load", {p, r}, model_out());
    chk("seed_done_ready", seed_ready, 0);
    warm();
    seq_a[0] = model_out();
    enable = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      model_adv();
      seq_a[i] = model_out();
      chk("zero_run", {p, r}, seq_a[i]);
    end

    // Reseed with same-cycle enable: no advance, back to SEED
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    enable = 1'b0;
    chk("reseed_valid", valid, 0);
    chk("reseed_ready", seed_ready, 1);
    chk("reseed_hold", {p, r}, seq_a[3]);

    // Seed 1 must reproduce the zero-seed sequence
    seed_two(32'h0000_0001, 32'h9ABC_DEF0);
    warm();
    chk("one_run_first", {p, r}, seq_a[0]);
    enable = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("one_vs_zero", {p, r}, seq_a[i]);
    end
    enable = 1'b0;

    // Multi-LFSR seeding with stall pattern 1,0,0,1,1,1
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    seed_two(32'h1234_5678, 32'h9ABC_DEF0);
    chk("multi_load", {p, r}, 48'hDEF0_1234_5678);
    warm();
    pat = 6'b111001;
    for (int i = 0; i < 6; i++) begin
      prev   = {p, r};
      enable = pat[i];
      tick();
      if (pat[i]) begin
        model_adv();
        compared++;
        assert ({p, r} !== prev) else begin
          mismatched++;
          $error("FAIL run_differs: observed %0h expected not %0h", {p, r}, prev);
        end
      end
      chk("multi_stall", {p, r}, model_out());
    end
    enable = 1'b0;

    // Reseed in SEED outranks a same-cycle accept
    reseed = 1'b1;
    tick();
    reseed     = 1'b0;
    seed_valid = 1'b1;
    seed       = 32'hAAAA_0001;
    tick();
    reseed = 1'b1;
    seed   = 32'hBBBB_0002;
    tick();
    reseed     = 1'b0;
    seed_valid = 1'b0;
    seed_two(32'h0BAD_F00D, 32'hC0FF_EE00);
    chk("reseed_k0", {p, r}, 48'hEE00_0BAD_F00D);

    // Reset during the second seed word drops it
    reseed = 1'b1;
    tick();
    reseed     = 1'b0;
    seed_valid = 1'b1;
    seed       = 32'hDEAD_BEEF;
    tick();
    reset = 1'b1;
    seed  = 32'h5555_5555;
    tick();
    reset      = 1'b0;
    seed_valid = 1'b0;
    chk("mid_rst_ready", seed_ready, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_out", {p, r}, rst_cat[47:0]);
    tick();
    chk("mid_rst_seed", seed_ready, 1);
    seed_two(32'h1111_1111, 32'h2222_2222);
    chk("post_rst_load", {p, r}, 48'h2222_1111_1111);
    warm();
    enable = 1'b1;
    tick();
    model_adv();
    chk("post_rst_run", {p, r}, model_out());
    chk("final_error", error, 0);
    enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/masked_rand_source.md
Name: masked_rand_source

Overview:
- Fresh-randomness generator feeding the masked HPC1 multipliers of the S-box datapath.
- Each enabled cycle it produces one refresh vector for `in_r` (NUM_SHARES words) and one pair-mask vector for `in_p` (NUM_QUAD words).
- Built from a bank of 32-bit LFSRs, seeded word-by-word over a valid/ready handshake.
- Sits directly upstream of the multiplier's randomness inputs. Outputs are registered, so they are stable for one full cycle.

Parameters:
- NUM_SHARES, 2, number of shares of the consuming multiplier.
- BIT_WIDTH, 1, width of one share word.
- WARMUP_CYCLES, 4, number of free-running advances after seeding before output is declared valid; must be ≥1.

Ports:
- in_clock  input  1  clock.
- in_reset  input  1  synchronous, active-high reset.
- in_seed  input  32  seed word.
- in_seed_valid  input  1  seed word present.
- out_seed_ready  output  1  seed word accepted this cycle when high together with in_seed_valid.
- in_reseed  input  1  request to discard state and re-enter seeding.
- in_enable  input  1  advance the generator (consumer takes the current vector).
- out_r  output  NUM_SHARES*BIT_WIDTH  refresh randomness, share i at bits [i*BIT_WIDTH +: BIT_WIDTH].
- out_p  output  NUM_QUAD*BIT_WIDTH  pair randomness, indexed by package qindex.
- out_valid  output  1  out_r/out_p are fresh, seeded randomness.
- out_error  output  1  sticky health failure; constant 0 without the optional feature.

Behaviour:
- Sizing:
  - NUM_QUAD = num_quad(NUM_SHARES) = NUM_SHARES*(NUM_SHARES-1)/2.
  - OUT_BITS = (NUM_SHARES+NUM_QUAD)*BIT_WIDTH.
  - NUM_LFSR = ceil(OUT_BITS/32).
- LFSR polynomial: x^32+x^22+x^2+x+1, Fibonacci form. Each advance performs 32 unrolled single-bit steps, so every state word is fully replaced.
- Output mapping: {out_p, out_r} = low OUT_BITS of the concatenation {lfsr[NUM_LFSR-1], …, lfsr[0]}. Outputs are driven from the state registers directly, with no extra latency.
- FSM states and transitions:
  - IDLE:
    - Entered on reset.
    - out_seed_ready=0, out_valid=0.
    - Moves to SEED the next cycle.
  - SEED:
    - out_seed_ready=1.
    - On each accept, word k loads into lfsr[k] and counter k increments.
    - A zero seed word is replaced by 32'h0000_0001.
    - After word NUM_LFSR-1 is accepted, moves to WARMUP with warm counter = 0.
  - WARMUP:
    - Advances every cycle regardless of in_enable.
    - After WARMUP_CYCLES advances, moves to RUN.
  - RUN:
    - out_valid=1.
    - All LFSRs advance in a cycle exactly when in_enable=1; otherwise outputs hold.
- Reset values:
  - State IDLE, k=0, warm counter=0.
  - lfsr[k] = 32'hACE1_0000 + k (nonzero).
  - out_valid=0, out_seed_ready=0, out_error=0.
- Reset mid-operation: takes priority over everything, including a seed word being accepted in the same cycle; that word is dropped.
- in_reseed:
  - From any non-IDLE state, the next state is SEED with k=0 and out_valid=0.
  - The LFSR contents are retained until overwritten by new seed words.
  - In SEED, in_reseed restarts at k=0 and takes priority over a same-cycle accept.
- in_enable outside RUN has no effect. in_seed_valid outside SEED is ignored.
- In RUN, consecutive valid outputs differ. The consumer must never reuse a vector across two multiplications without asserting in_enable.

Optional Feature:
- Macro: RAND_SOURCE_HEALTH_EN.
- When defined, a repetition check is added:
  - Each RUN advance compares the new lfsr[0] with its previous value.
  - Any equal pair, or any LFSR state reaching all-zero, sets out_error sticky.
  - out_error forces out_valid=0.
  - Only in_reset clears out_error; in_reseed does not.
- When not defined: out_error is tied to 0 and no comparison logic is present.

Decomposition:
- aes128_package additions:
  - num_quad and qindex (shared with the multiplier).
  - LFSR_WIDTH=32.
  - LFSR_TAPS constant.
  - Reset-seed base 32'hACE1_0000.
  - Function lfsr_advance32(state) returning the state after 32 steps.
- One sub-module, lfsr32_unrolled: a single registered LFSR with load, advance and zero-substitution. It is instantiated NUM_LFSR times, and the register module is used for its state.

Test Plan:
- Reset and idle:
  - Reset, then hold in_seed_valid=0 → out_seed_ready=1 from cycle 2 onward.
  - out_valid stays 0 indefinitely.
  - out_r/out_p equal the reset seeds 32'hACE1_0000+k.
- Zero seed (NUM_SHARES=2, BIT_WIDTH=8, so NUM_LFSR=1):
  - Seed 0x0000_0000 produces a RUN output sequence identical to seed 0x0000_0001.
  - out_valid rises exactly WARMUP_CYCLES+1 cycles after the accept.
- Multi-LFSR seeding (NUM_SHARES=3, BIT_WIDTH=8, so OUT_BITS=48, NUM_LFSR=2):
  - Seeds 0x1234_5678, 0x9ABC_DEF0 → outputs match a reference model using lfsr_advance32 for every enabled cycle.
- Stall:
  - in_enable toggled 1,0,0,1 in RUN → outputs change only on the two enabled cycles and hold bit-exact otherwise.
- Reseed and reset collisions:
  - in_reseed asserted in RUN together with in_enable → out_valid=0 next cycle, SEED with k=0, and the previous vector does not advance.
  - in_reset asserted during the second seed word → IDLE, with the word dropped.
- Health check (RAND_SOURCE_HEALTH_EN):
  - Force lfsr[0] to 0 → out_error=1 and out_valid=0 next cycle.
  - Still set after in_reseed; cleared only by in_reset.
